// File: rtl/pe_drain.sv
// pe_drain: collects N_WORDS addressed words from a PE in any order, then streams
// them out in address order over a valid/ready handshake.
`default_nettype none

module pe_drain #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 3,
  parameter int N_WORDS    = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_start,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE,
  input  logic                             i_PE_valid,
  output logic [ADDR_WIDTH-1:0]            o_addr,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    STREAM  = 2'd2,
    DONE    = 2'd3
  } state_t;

  // One extra bit so N_WORDS == 2^ADDR_WIDTH is representable in the range check.
  localparam logic [ADDR_WIDTH:0]   NW_W   = (ADDR_WIDTH+1)'(N_WORDS);
  localparam logic [ADDR_WIDTH-1:0] LAST_W = ADDR_WIDTH'(N_WORDS - 1);

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
  logic [N_WORDS-1:0]     bitmap_q, bitmap_d;
  logic                   err_q, err_d;
  logic [DATA_WIDTH-1:0]  mem_q [N_WORDS];

  logic [ADDR_WIDTH-1:0]  pe_addr;
  logic [DATA_WIDTH-1:0]  pe_data;
  logic                   in_range;
  logic                   wr_en;

  assign pe_addr  = i_PE[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign pe_data  = i_PE[DATA_WIDTH-1:0];
  assign in_range = ({1'b0, pe_addr} < NW_W);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    bitmap_d = bitmap_q;
    err_d    = err_q;
    wr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d  = CAPTURE;
          idx_d    = '0;
          bitmap_d = '0;
          err_d    = 1'b0;
        end
      end
      CAPTURE: begin
        if (i_PE_valid) begin
          if (in_range) begin
            wr_en = 1'b1;
            if (bitmap_q[pe_addr]) err_d = 1'b1;
            bitmap_d[pe_addr] = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        // Leave on the same edge as the completing write so o_valid follows one cycle later.
        if (&bitmap_d) begin
          state_d = STREAM;
          idx_d   = '0;
        end
      end
      STREAM: begin
        if (i_ready) begin
          if (idx_q == LAST_W) state_d = DONE;
          else                 idx_d   = idx_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      bitmap_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      bitmap_q <= bitmap_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[pe_addr] <= pe_data;
  end

  assign o_valid = (state_q == STREAM);
  assign o_done  = (state_q == DONE);
  assign o_busy  = (state_q != IDLE);
  assign o_err   = err_q;
  assign o_addr  = idx_q;
  assign o_data  = mem_q[idx_q];

endmodule

`default_nettype wire

// File: tb/tb_pe_drain.sv
// tb_pe_drain: directed checks of capture, in-order streaming, backpressure,
// duplicate-address error, start/PE-valid ignore rules and mid-stream abort.
`default_nettype none

module tb_pe_drain;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start;
  logic [5:0] i_PE;
  logic       i_PE_valid;
  logic [2:0] o_addr;
  logic [2:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_busy;
  logic       o_done;
  logic       o_err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [2:0] exp_data [8];
  int         ord [8] = '{7, 3, 0, 5, 1, 6, 2, 4};

  pe_drain #(.ADDR_WIDTH(3), .DATA_WIDTH(3), .N_WORDS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_PE       (i_PE),
    .i_PE_valid (i_PE_valid),
    .o_addr     (o_addr),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] a, input logic [2:0] d);
    i_PE_valid = 1'b1;
    i_PE       = {a, d};
    step();
    i_PE_valid = 1'b0;
    i_PE       = '0;
  endtask

  task automatic start_cap(input logic with_pe, input logic [5:0] pe);
    i_start    = 1'b1;
    i_PE_valid = with_pe;
    i_PE       = pe;
    step();
    i_start    = 1'b0;
    i_PE_valid = 1'b0;
    i_PE       = '0;
    chk("busy_after_start", {31'd0, o_busy}, 32'd1);
    chk("err_clear_on_start", {31'd0, o_err}, 32'd0);
  endtask

  // Walks the stream with optional stall, stray start pulse and abort via rst.
  task automatic run_stream(input int stall_idx, input int stall_len,
                            input int start_idx, input int abort_idx,
                            input logic exp_err);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_idx) begin
        rst = 1'b1;
        #1;
        chk("abort_valid", {31'd0, o_valid}, 32'd0);
        chk("abort_busy",  {31'd0, o_busy},  32'd0);
        step();
        chk("abort_no_done", {31'd0, o_done}, 32'd0);
        chk("abort_idle_busy", {31'd0, o_busy}, 32'd0);
        rst = 1'b0;
        return;
      end
      if (i == stall_idx) begin
        i_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          chk("stall_valid", {31'd0, o_valid}, 32'd1);
          chk("stall_addr",  {29'd0, o_addr}, i[31:0]);
          chk("stall_data",  {29'd0, o_data}, {29'd0, exp_data[i]});
          step();
        end
        i_ready = 1'b1;
      end
      chk("beat_valid", {31'd0, o_valid}, 32'd1);
      chk("beat_addr",  {29'd0, o_addr}, i[31:0]);
      chk("beat_data",  {29'd0, o_data}, {29'd0, exp_data[i]});
      chk("beat_done",  {31'd0, o_done}, 32'd0);
      chk("beat_err",   {31'd0, o_err},  {31'd0, exp_err});
      if (i == start_idx) i_start = 1'b1;
      step();
      i_start = 1'b0;
    end
    chk("done_pulse", {31'd0, o_done},  32'd1);
    chk("done_valid", {31'd0, o_valid}, 32'd0);
    chk("done_busy",  {31'd0, o_busy},  32'd1);
    step();
    chk("done_once",  {31'd0, o_done},  32'd0);
    chk("idle_busy",  {31'd0, o_busy},  32'd0);
    chk("end_err",    {31'd0, o_err},   {31'd0, exp_err});
  endtask

  initial begin
    rst        = 1'b1;
    i_start    = 1'b0;
    i_PE       = '0;
    i_PE_valid = 1'b0;
    i_ready    = 1'b1;
    step();
    step();
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_busy",  {31'd0, o_busy},  32'd0);
    chk("rst_done",  {31'd0, o_done},  32'd0);
    chk("rst_err",   {31'd0, o_err},   32'd0);
    rst = 1'b0;
    step();

    // In-order capture, data = addr ^ 5 -> 5,4,7,6,1,0,3,2
    exp_data = '{3'd5, 3'd4, 3'd7, 3'd6, 3'd1, 3'd0, 3'd3, 3'd2};
    start_cap(1'b0, 6'd0);
    for (int a = 0; a < 8; a++) begin
      chk("cap_no_valid", {31'd0, o_valid}, 32'd0);
      send(a[2:0], a[2:0] ^ 3'b101);
    end
    chk("valid_latency", {31'd0, o_valid}, 32'd1);
    run_stream(-1, 0, -1, -1, 1'b0);

    // Out-of-order capture with a 3-cycle stall at idx 2
    start_cap(1'b0, 6'd0);
    for (int k = 0; k < 8; k++) send(ord[k][2:0], ord[k][2:0] ^ 3'b101);
    run_stream(2, 3, -1, -1, 1'b0);

    // Duplicate address 3: first data 1, then 6
    exp_data[3] = 3'd6;
    start_cap(1'b0, 6'd0);
    send(3'd3, 3'd1);
    chk("dup_err_before", {31'd0, o_err}, 32'd0);
    send(3'd3, 3'd6);
    chk("dup_err_set", {31'd0, o_err}, 32'd1);
    chk("dup_no_valid", {31'd0, o_valid}, 32'd0);
    for (int a = 0; a < 8; a++) begin
      if (a != 3) send(a[2:0], a[2:0] ^ 3'b101);
    end
    run_stream(-1, 0, -1, -1, 1'b1);

    // Start with a simultaneous PE word (must be discarded), stray PE word in IDLE,
    // stray start during STREAM, then abort at idx 4.
    exp_data[3] = 3'd6;
    i_PE_valid = 1'b1;
    i_PE       = {3'd1, 3'd7};
    step();
    i_PE_valid = 1'b0;
    chk("idle_pe_ignored", {31'd0, o_busy}, 32'd0);
    start_cap(1'b1, {3'd0, 3'd7});
    for (int a = 0; a < 8; a++) send(a[2:0], a[2:0] ^ 3'b101);
    chk("simul_word_no_err", {31'd0, o_err}, 32'd0);
    run_stream(-1, 0, 2, 4, 1'b0);

    // Fresh capture after abort, data = addr ^ 2
    exp_data = '{3'd2, 3'd3, 3'd0, 3'd1, 3'd6, 3'd7, 3'd4, 3'd5};
    start_cap(1'b0, 6'd0);
    for (int a = 7; a >= 0; a--) send(a[2:0], a[2:0] ^ 3'b010);
    run_stream(5, 2, -1, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pe_drain.md
PE_DRAIN -- requirements
Module: pe_drain

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 3, width of the PE address field.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 3, width of the PE data field.
REQ-003 The block SHALL have parameter N_WORDS, default 8, number of words to collect; legal range 1..2^ADDR_WIDTH.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-006 The block SHALL have port i_start, input, 1, single-cycle request to begin a capture.
REQ-007 The block SHALL have port i_PE, input, ADDR_WIDTH+DATA_WIDTH, PE output word, packed as {addr[MSBs], data[LSBs]}.
REQ-008 The block SHALL have port i_PE_valid, input, 1, qualifies i_PE.
REQ-009 The block SHALL have port o_addr, output, ADDR_WIDTH, streamed word address.
REQ-010 The block SHALL have port o_data, output, DATA_WIDTH, streamed word data.
REQ-011 The block SHALL have port o_valid, output, 1, o_addr/o_data valid.
REQ-012 The block SHALL have port i_ready, input, 1, downstream accepts the beat.
REQ-013 The block SHALL have port o_busy, output, 1, high in any state except IDLE.
REQ-014 The block SHALL have port o_done, output, 1, one-cycle pulse at the end of a stream.
REQ-015 The block SHALL have port o_err, output, 1, sticky error flag; cleared by rst or by an accepted i_start.

Function
REQ-016 The FSM SHALL have states IDLE, CAPTURE, STREAM and DONE.
REQ-017 In IDLE, i_start=1 SHALL cause a transition to CAPTURE on the next edge, clearing the N_WORDS-bit filled bitmap and o_err.
REQ-018 In CAPTURE, each cycle with i_PE_valid=1 and addr<N_WORDS SHALL write mem[addr]=data and set bitmap[addr].
REQ-019 A captured addr whose bitmap bit is already set SHALL overwrite mem[addr] and set o_err.
REQ-020 A captured addr>=N_WORDS SHALL be discarded and set o_err.
REQ-021 CAPTURE SHALL move to STREAM on the edge after the write that makes the bitmap all-ones, giving 1 cycle of latency from the last write to the first o_valid.
REQ-022 In STREAM, o_valid SHALL be 1, o_addr SHALL equal idx, and o_data SHALL equal mem[idx], with idx starting at 0.
REQ-023 In STREAM, idx SHALL increment only when o_valid&&i_ready.
REQ-024 o_addr/o_data SHALL hold stable while o_valid=1 and i_ready=0.
REQ-025 When the beat at idx=N_WORDS-1 is accepted, the FSM SHALL move to DONE.
REQ-026 In DONE, o_done SHALL be 1 for exactly one cycle and o_valid SHALL be 0; the FSM SHALL then return to IDLE.
REQ-027 i_start SHALL be ignored in CAPTURE, STREAM and DONE.
REQ-028 i_PE_valid SHALL be ignored outside CAPTURE.
REQ-029 Simultaneous i_start and i_PE_valid in IDLE SHALL start the capture only; the word SHALL be discarded.
REQ-030 o_valid, o_done, o_busy and o_err SHALL be driven from registers, with no combinational path from any input.

Reset
REQ-031 While rst=1, the FSM SHALL be IDLE, and idx, bitmap, o_valid, o_done, o_busy and o_err SHALL all be 0.
REQ-032 mem contents SHALL NOT be required to reset.
REQ-033 Asserting rst mid-CAPTURE or mid-STREAM SHALL abort the operation immediately, with no o_done pulse.

Verification
REQ-034 Reset: hold rst=1 for 2 cycles -> o_valid=0, o_busy=0, o_done=0, o_err=0.
REQ-035 In-order capture with i_ready=1: i_start, then words {a,a^3'b101} for a=0..7 -> o_valid rises 1 cycle after the last word; 8 beats with o_addr 0..7 and o_data 5,4,7,6,1,0,3,2; o_done pulses once; o_err=0.
REQ-036 Out-of-order capture: words with addresses 7,3,0,5,1,6,2,4 -> stream still emits o_addr 0..7 in order with the matching data.
REQ-037 Backpressure: i_ready=0 for 3 cycles at idx=2 -> o_addr=2 and o_data held constant; no beat lost or duplicated.
REQ-038 Error: address 3 sent twice (data 1, then 6), then the remaining addresses -> o_err=1, beat 3 carries data 6, and the stream completes normally.
REQ-039 Abort and ignore: i_start pulsed during STREAM -> no effect; rst pulsed at idx=4 -> o_valid=0 and o_busy=0 while rst=1, no o_done pulse, and a new capture then works normally.
